// File: rtl/digit_serial_adder_if.sv
// Operand/result bundle for digit_serial_adder: start/busy/done handshake plus
// operands and registered results.
interface digit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             Overflow;

  modport master (
    output start, sub, x, y, cin,
    input  busy, done, Sum, Carry, Overflow
  );

  modport slave (
    input  start, sub, x, y, cin,
    output busy, done, Sum, Carry, Overflow
  );
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a chain of full
// adder cells, one carry flip-flop between digits, results registered on DONE.
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  digit_serial_adder_if.slave  bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic             c_q;
  logic             sub_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q, ovf_q;

  logic             accept, last;
  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic [DIGIT:0]   ch;
  logic [WIDTH-1:0] acc_d;

  assign accept = bus.start && (state_q != S_RUN);
  assign last   = (k_q == KW'(NDIG - 1));

  // Digit datapath. Digit k is picked with constant-base slices so operands
  // stay untouched for the whole operation.
  // NOTE: every variable driven here gets a default first, so no path through
  // the loops can leave one unassigned and infer a latch.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    s_dig = '0;
    ch    = '0;
    acc_d = acc_q;
    for (int d = 0; d < NDIG; d++) begin
      if (k_q == KW'(d)) begin
        a_dig = a_q[d*DIGIT +: DIGIT];
        b_dig = b_q[d*DIGIT +: DIGIT];
      end
    end
    ch[0] = c_q;
    for (int i = 0; i < DIGIT; i++) begin
      s_dig[i]  = a_dig[i] ^ b_dig[i] ^ ch[i];
      ch[i+1]   = (a_dig[i] & b_dig[i]) | (ch[i] & (a_dig[i] ^ b_dig[i]));
    end
    for (int d = 0; d < NDIG; d++) begin
      if (k_q == KW'(d)) acc_d[d*DIGIT +: DIGIT] = s_dig;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = accept ? S_RUN : S_IDLE;
      S_RUN:          if (last) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Subtraction is x + ~y + ~cin; sub_q restores borrow polarity at the end.
        a_q   <= bus.x;
        b_q   <= bus.y ^ {WIDTH{bus.sub}};
        c_q   <= bus.cin ^ bus.sub;
        sub_q <= bus.sub;
        k_q   <= '0;
      end else if (state_q == S_RUN) begin
        acc_q <= acc_d;
        c_q   <= ch[DIGIT];
        k_q   <= last ? '0 : k_q + KW'(1);
        if (last) begin
          sum_q   <= acc_d;
          carry_q <= ch[DIGIT] ^ sub_q;
          ovf_q   <= ch[DIGIT-1] ^ ch[DIGIT];
        end
      end
    end
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.Sum      = sum_q;
  assign bus.Carry    = carry_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised sequential adder/subtractor, the successor to the single-bit structural full adder. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, keeping one carry flip-flop between digits. A start/busy/done handshake frames each operation. It is the arithmetic unit for the multi-bit datapath labs, where area matters more than latency.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 1.
- DIGIT, 1, bits processed per cycle; WIDTH must be an integer multiple of DIGIT.
- NDIG, derived, WIDTH/DIGIT: digits per operation, which is also the cycle count.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is able to accept (see Operation).
- sub  input  1  0 = add, 1 = subtract; captured with start.
- x  input  WIDTH  operand A; captured with start.
- y  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in (borrow-in when sub=1); captured with start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when the result registers update.
- Sum  output  WIDTH  result, registered.
- Carry  output  1  carry-out (borrow-out when sub=1), registered.
- Overflow  output  1  two's-complement signed overflow, registered.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, with a digit index k running 0..NDIG-1.
  - DONE: busy=0, done=1; lasts exactly one cycle.
- Accept condition: state is IDLE or DONE, and start=1.
  - On accept, latch x into A, y^{WIDTH{sub}} into B, and cin^sub into the carry flip-flop.
  - Set k=0 and go to RUN.
- start while in RUN is ignored. Latched operands are never modified mid-operation.
- RUN, each cycle:
  - Add digit k of A and B to the carry register, using DIGIT chained full-adder cells.
  - Store the DIGIT-bit result into a shift/accumulate register at bit position k*DIGIT.
  - Update the carry flip-flop and increment k.
- After the cycle processing k=NDIG-1, go to DONE and load the output registers:
  - Sum = accumulated result.
  - Carry = final carry ^ sub. When sub=1 this is a borrow: 1 means x < y + cin.
  - Overflow = carry into MSB XOR carry out of MSB, both raw (not sub-corrected).
- Result values:
  - sub=0: Sum = (x + y + cin) mod 2^WIDTH.
  - sub=1: Sum = (x − y − cin) mod 2^WIDTH.
- DONE goes to RUN if an accept occurs that cycle, otherwise to IDLE.
- Sum, Carry and Overflow hold their value from one DONE to the next. They do not change during RUN.
- Reset (rst=1 at an edge) overrides everything, including mid-RUN:
  - State returns to IDLE.
  - busy=0, done=0, Sum=0, Carry=0, Overflow=0.
  - The carry flip-flop, accumulator and k are cleared.
  - A start asserted in the same cycle as rst is dropped.

## Timing
- Accept edge E0.
- Digits are processed at edges E1..E(NDIG).
- busy is high from after E0 through E(NDIG).
- done=1 and the new Sum/Carry/Overflow are visible in the cycle after E(NDIG).
- Latency is NDIG cycles from accept to done.
- Throughput: a start held high in the DONE cycle is accepted. This gives back-to-back operations every NDIG+1 cycles with no IDLE gap.
- WIDTH=DIGIT (NDIG=1) behaves as a one-cycle registered adder: done in the cycle after E1.
- There are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=1, DIGIT=1, all 8 (x,y,cin) combinations with sub=0 → Sum/Carry match the full-adder truth table, e.g. 1,1,1 → Sum=1, Carry=1. done arrives 1 cycle after each accept.
- WIDTH=8, DIGIT=1, add tests; done asserts exactly 8 cycles after accept:
  - x=8'h5A, y=8'hC3, cin=0 → Sum=8'h1D, Carry=1, Overflow=0.
  - x=8'h7F, y=8'h01 → Sum=8'h80, Carry=0, Overflow=1.
- WIDTH=8, DIGIT=1, subtract tests:
  - sub=1, x=8'h10, y=8'h20, cin=0 → Sum=8'hF0, Carry=1, Overflow=0.
  - x=8'h80, y=8'h01 → Sum=8'h7F, Carry=0, Overflow=1.
- WIDTH=8, DIGIT=4: x=8'hFF, y=8'h01, cin=1 → Sum=8'h01, Carry=1, done after 2 cycles. Then a second start held in the DONE cycle with x=8'h03, y=8'h04 is accepted immediately → Sum=8'h07 after 2 more cycles.
- WIDTH=8, DIGIT=1, start re-pulsed with new operands at RUN cycle 4 → ignored; the first result is unchanged.
- WIDTH=8, DIGIT=1, rst asserted at RUN cycle 3 → next cycle busy=0, done=0, Sum=0, Carry=0, Overflow=0. A fresh operation then completes correctly.
